// File: rtl/anc_fir_seq.sv
// ANC filter sequencer: captures sample sets, launches the filter datapath, buffers its result.
// Optional WAIT timeout abort is enabled by defining ANC_FIR_SEQ_TIMEOUT_EN.
module anc_fir_seq #(
  parameter int                 TIMEOUT_CYCLES = 300,
  parameter logic signed [15:0] MU_DEFAULT     = 16'sh0100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_strobe,
  input  logic [15:0] x_sample,
  input  logic [15:0] a_sample,
  input  logic [15:0] err_sample,
  input  logic        mu_wr,
  input  logic [15:0] mu_val,
  output logic [15:0] fir_x_in,
  output logic [15:0] fir_a_in,
  output logic [15:0] fir_weight_adjust,
  output logic        fir_go,
  input  logic        fir_done,
  input  logic [15:0] fir_out_sample,
  output logic [15:0] out_sample,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic [7:0]  drop_cnt,
  output logic        timeout_flag,
  input  logic        clr_flags
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2
  } state_t;

  state_t             state;
  logic signed [15:0] mu;
  logic signed [31:0] product;
  logic signed [31:0] shifted;
  logic [15:0]        weight_next;
  logic               accept;
  logic               drop;

  function automatic logic [15:0] sat16(input logic signed [31:0] v);
    if (v > 32'sd32767) begin
      return 16'h7FFF;
    end else if (v < -32'sd32768) begin
      return 16'h8000;
    end else begin
      return v[15:0];
    end
  endfunction

  // Weight adjustment from the step size currently held (a same-cycle mu_wr lands one cycle later).
  always_comb begin
    product     = $signed(mu) * $signed(err_sample);
    shifted     = product >>> 15;
    weight_next = sat16(shifted);
  end

  assign accept = in_strobe && (state == IDLE) && (!out_valid || out_ready);
  assign drop   = in_strobe && !accept;
  assign busy   = (state == LAUNCH) || (state == WAIT);

`ifdef ANC_FIR_SEQ_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wait_cnt;
  logic          timeout_r;
  assign timeout_flag = timeout_r;
`else
  assign timeout_flag = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= IDLE;
      mu                <= MU_DEFAULT;
      fir_x_in          <= 16'h0000;
      fir_a_in          <= 16'h0000;
      fir_weight_adjust <= 16'h0000;
      fir_go            <= 1'b0;
      out_sample        <= 16'h0000;
      out_valid         <= 1'b0;
      drop_cnt          <= 8'h00;
`ifdef ANC_FIR_SEQ_TIMEOUT_EN
      wait_cnt          <= '0;
      timeout_r         <= 1'b0;
`endif
    end else begin
      fir_go <= 1'b0;
      if (mu_wr) begin
        mu <= mu_val;
      end
      if (clr_flags) begin
        drop_cnt <= 8'h00;
      end else if (drop && (drop_cnt != 8'hFF)) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
      // Handshake clears the buffer; a capture in WAIT below overrides it.
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (accept) begin
            fir_x_in          <= x_sample;
            fir_a_in          <= a_sample;
            fir_weight_adjust <= weight_next;
            fir_go            <= 1'b1;
            state             <= LAUNCH;
          end
        end
        LAUNCH: begin
          state <= WAIT;
`ifdef ANC_FIR_SEQ_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        WAIT: begin
          if (fir_done) begin
            out_sample <= fir_out_sample;
            out_valid  <= 1'b1;
            state      <= IDLE;
`ifdef ANC_FIR_SEQ_TIMEOUT_EN
          end else if (wait_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            state     <= IDLE;
            timeout_r <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + {{(CW-1){1'b0}}, 1'b1};
`endif
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
`ifdef ANC_FIR_SEQ_TIMEOUT_EN
      if (clr_flags) begin
        timeout_r <= 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_anc_fir_seq.sv
// Directed self-checking bench for anc_fir_seq; inputs change 1ns after the rising edge, outputs are checked there.
module tb_anc_fir_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_strobe = 1'b0;
  logic [15:0] x_sample = 16'h0000;
  logic [15:0] a_sample = 16'h0000;
  logic [15:0] err_sample = 16'h0000;
  logic        mu_wr = 1'b0;
  logic [15:0] mu_val = 16'h0000;
  logic [15:0] fir_x_in, fir_a_in, fir_weight_adjust;
  logic        fir_go;
  logic        fir_done = 1'b0;
  logic [15:0] fir_out_sample = 16'h0000;
  logic [15:0] out_sample;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        busy;
  logic [7:0]  drop_cnt;
  logic        timeout_flag;
  logic        clr_flags = 1'b0;

  int passed = 0;
  int total  = 0;

  anc_fir_seq dut (
    .clk(clk), .rst(rst), .in_strobe(in_strobe),
    .x_sample(x_sample), .a_sample(a_sample), .err_sample(err_sample),
    .mu_wr(mu_wr), .mu_val(mu_val),
    .fir_x_in(fir_x_in), .fir_a_in(fir_a_in), .fir_weight_adjust(fir_weight_adjust),
    .fir_go(fir_go), .fir_done(fir_done), .fir_out_sample(fir_out_sample),
    .out_sample(out_sample), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .drop_cnt(drop_cnt), .timeout_flag(timeout_flag), .clr_flags(clr_flags)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_mu(input logic [15:0] v);
    mu_wr = 1'b1; mu_val = v;
    step();
    mu_wr = 1'b0;
  endtask

  // Accept a sample set and advance into WAIT.
  task automatic start_txn(input logic [15:0] x, input logic [15:0] a, input logic [15:0] e);
    in_strobe = 1'b1; x_sample = x; a_sample = a; err_sample = e;
    step();
    in_strobe = 1'b0;
    step();
  endtask

  task automatic finish_txn(input logic [15:0] d);
    fir_done = 1'b1; fir_out_sample = d;
    step();
    fir_done = 1'b0; out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    step(); step();
    total++; if ({fir_go, busy, out_valid, timeout_flag} !== 4'b0000) $display("FAIL reset_ctrl: got %b exp 0000", {fir_go, busy, out_valid, timeout_flag}); else passed++;
    total++; if ({fir_x_in, fir_a_in, fir_weight_adjust, out_sample, drop_cnt} !== 72'h0) $display("FAIL reset_data: got %h exp 0", {fir_x_in, fir_a_in, fir_weight_adjust, out_sample, drop_cnt}); else passed++;
    rst = 1'b0;
    fir_done = 1'b1; fir_out_sample = 16'h7777;
    step();
    fir_done = 1'b0;
    total++; if ({out_valid, busy} !== 2'b00) $display("FAIL reset_done_ignored: got %b exp 00", {out_valid, busy}); else passed++;
  endtask

  task automatic test_basic();
    write_mu(16'h4000);
    in_strobe = 1'b1; x_sample = 16'h1234; a_sample = 16'h5555; err_sample = 16'h2000;
    total++; if (fir_go !== 1'b0) $display("FAIL basic_go_early: got %b exp 0", fir_go); else passed++;
    step();
    in_strobe = 1'b0;
    total++; if ({fir_go, busy} !== 2'b11) $display("FAIL basic_launch: got %b exp 11", {fir_go, busy}); else passed++;
    total++; if (fir_weight_adjust !== 16'h1000) $display("FAIL basic_weight: got %h exp 1000", fir_weight_adjust); else passed++;
    total++; if ({fir_x_in, fir_a_in} !== 32'h1234_5555) $display("FAIL basic_operands: got %h exp 12345555", {fir_x_in, fir_a_in}); else passed++;
    step();
    total++; if ({fir_go, busy} !== 2'b01) $display("FAIL basic_wait: got %b exp 01", {fir_go, busy}); else passed++;
    fir_done = 1'b1; fir_out_sample = 16'h0042;
    step();
    fir_done = 1'b0;
    total++; if ({out_valid, busy, out_sample} !== {2'b10, 16'h0042}) $display("FAIL basic_result: got %b %h exp 10 0042", {out_valid, busy}, out_sample); else passed++;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    total++; if (out_valid !== 1'b0) $display("FAIL basic_drain: got %b exp 0", out_valid); else passed++;
  endtask

  task automatic test_saturation();
    write_mu(16'h8000);
    start_txn(16'h0001, 16'h0002, 16'h8000);
    total++; if (fir_weight_adjust !== 16'h7FFF) $display("FAIL sat_pos: got %h exp 7fff", fir_weight_adjust); else passed++;
    finish_txn(16'h0003);
  endtask

  task automatic test_mu_coincident();
    mu_wr = 1'b1; mu_val = 16'h4000;
    in_strobe = 1'b1; x_sample = 16'h0010; err_sample = 16'h2000;
    step();
    mu_wr = 1'b0; in_strobe = 1'b0;
    total++; if (fir_weight_adjust !== 16'hE000) $display("FAIL mu_old_used: got %h exp e000", fir_weight_adjust); else passed++;
    step();
    finish_txn(16'h0004);
    start_txn(16'h0011, 16'h0000, 16'h2000);
    total++; if (fir_weight_adjust !== 16'h1000) $display("FAIL mu_new_used: got %h exp 1000", fir_weight_adjust); else passed++;
    finish_txn(16'h0005);
  endtask

  task automatic test_output_hold();
    start_txn(16'h0020, 16'h0021, 16'h0000);
    fir_done = 1'b1; fir_out_sample = 16'hABCD;
    step();
    fir_done = 1'b0; fir_out_sample = 16'h0000;
    for (int i = 1; i <= 4; i++) begin
      total++; if ({out_valid, out_sample} !== {1'b1, 16'hABCD}) $display("FAIL hold_T%0d: got %b %h exp 1 abcd", i, out_valid, out_sample); else passed++;
      step();
    end
    out_ready = 1'b1;
    total++; if ({out_valid, out_sample} !== {1'b1, 16'hABCD}) $display("FAIL hold_T5: got %b %h exp 1 abcd", out_valid, out_sample); else passed++;
    step();
    out_ready = 1'b0;
    total++; if (out_valid !== 1'b0) $display("FAIL hold_T6: got %b exp 0", out_valid); else passed++;
  endtask

  task automatic test_done_ignored();
    fir_done = 1'b1; fir_out_sample = 16'h1111;
    step();
    fir_done = 1'b0;
    total++; if ({out_valid, busy, out_sample} !== {2'b00, 16'hABCD}) $display("FAIL done_ignored: got %b %h exp 00 abcd", {out_valid, busy}, out_sample); else passed++;
  endtask

  task automatic test_drop();
    start_txn(16'h0030, 16'h0031, 16'h0000);
    in_strobe = 1'b1; x_sample = 16'hDEAD;
    step(); step(); step();
    in_strobe = 1'b0;
    total++; if (drop_cnt !== 8'd3) $display("FAIL drop_three: got %0d exp 3", drop_cnt); else passed++;
    total++; if (fir_x_in !== 16'h0030) $display("FAIL drop_operands: got %h exp 0030", fir_x_in); else passed++;
    fir_done = 1'b1; fir_out_sample = 16'h0032;
    step();
    fir_done = 1'b0;
    in_strobe = 1'b1;
    for (int i = 0; i < 300; i++) step();
    in_strobe = 1'b0;
    total++; if ({drop_cnt, busy} !== {8'd255, 1'b0}) $display("FAIL drop_saturate: got %0d busy %b exp 255 busy 0", drop_cnt, busy); else passed++;
    clr_flags = 1'b1;
    step();
    clr_flags = 1'b0;
    total++; if (drop_cnt !== 8'd0) $display("FAIL drop_clear: got %0d exp 0", drop_cnt); else passed++;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_clear_coincident();
    start_txn(16'h0040, 16'h0041, 16'h0000);
    in_strobe = 1'b1;
    step();
    total++; if (drop_cnt !== 8'd1) $display("FAIL clr_pre: got %0d exp 1", drop_cnt); else passed++;
    clr_flags = 1'b1;
    step();
    in_strobe = 1'b0; clr_flags = 1'b0;
    total++; if (drop_cnt !== 8'd0) $display("FAIL clr_wins: got %0d exp 0", drop_cnt); else passed++;
    finish_txn(16'h0042);
  endtask

  task automatic test_timeout();
    int cycles;
    start_txn(16'h0050, 16'h0051, 16'h0000);
`ifdef ANC_FIR_SEQ_TIMEOUT_EN
    cycles = 0;
    while (busy && cycles < 400) begin
      step();
      cycles++;
    end
    total++; if ({busy, timeout_flag, out_valid} !== 3'b010) $display("FAIL timeout_abort: got %b exp 010 after %0d cycles", {busy, timeout_flag, out_valid}, cycles); else passed++;
    in_strobe = 1'b1; x_sample = 16'h0052;
    step();
    in_strobe = 1'b0;
    total++; if ({fir_go, fir_x_in} !== {1'b1, 16'h0052}) $display("FAIL timeout_next_accept: got %b %h exp 1 0052", fir_go, fir_x_in); else passed++;
    step();
    finish_txn(16'h0053);
    clr_flags = 1'b1;
    step();
    clr_flags = 1'b0;
    total++; if (timeout_flag !== 1'b0) $display("FAIL timeout_clear: got %b exp 0", timeout_flag); else passed++;
`else
    cycles = 0;
    while (busy && cycles < 350) begin
      step();
      cycles++;
    end
    total++; if ({busy, timeout_flag, out_valid} !== 3'b100) $display("FAIL wait_hold: got %b exp 100 after %0d cycles", {busy, timeout_flag, out_valid}, cycles); else passed++;
    finish_txn(16'h0053);
`endif
  endtask

  task automatic test_reset_mid_wait();
    start_txn(16'h0060, 16'h0061, 16'h7000);
    rst = 1'b1;
    #2;
    total++; if ({fir_go, busy, out_valid, fir_x_in, fir_a_in, fir_weight_adjust} !== 51'h0) $display("FAIL rst_async: got %h exp 0", {fir_go, busy, out_valid, fir_x_in, fir_a_in, fir_weight_adjust}); else passed++;
    step();
    rst = 1'b0; fir_done = 1'b1; fir_out_sample = 16'h5A5A;
    step();
    fir_done = 1'b0;
    total++; if ({out_valid, busy, out_sample, drop_cnt, timeout_flag} !== 27'h0) $display("FAIL rst_done_ignored: got %h exp 0", {out_valid, busy, out_sample, drop_cnt, timeout_flag}); else passed++;
    start_txn(16'h0062, 16'h0000, 16'h4000);
    total++; if (fir_weight_adjust !== 16'h0080) $display("FAIL rst_mu_default: got %h exp 0080", fir_weight_adjust); else passed++;
    finish_txn(16'h0063);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_mu_coincident();
    test_output_hold();
    test_done_ignored();
    test_drop();
    test_clear_coincident();
    test_timeout();
    test_reset_mid_wait();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/anc_fir_seq.md
ANC_FIR_SEQ -- requirements
Module: anc_fir_seq

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 300, maximum cycles in WAIT before abort.
REQ-002 Parameter MU_DEFAULT, default 16'sh0100, step size loaded at reset (Q1.15).
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_strobe  input  1  one-cycle pulse: new sample set present.
REQ-006 x_sample  input  16  reference sample, signed Q1.15.
REQ-007 a_sample  input  16  accumulator preload sample, signed Q1.15.
REQ-008 err_sample  input  16  error-mic sample, signed Q1.15.
REQ-009 mu_wr  input  1  load mu_val into step-size register.
REQ-010 mu_val  input  16  signed step size, Q1.15.
REQ-011 fir_x_in, fir_a_in, fir_weight_adjust  output  16 each  operands to filter datapath.
REQ-012 fir_go  output  1  one-cycle start pulse to filter datapath.
REQ-013 fir_done  input  1  filter completion pulse.
REQ-014 fir_out_sample  input  16  filter result, valid when fir_done=1.
REQ-015 out_sample  output  16  buffered result; out_valid  output  1; out_ready  input  1.
REQ-016 busy  output  1  high in LAUNCH or WAIT.
REQ-017 drop_cnt  output  8  saturating count of dropped strobes.
REQ-018 timeout_flag  output  1  sticky abort indicator; clr_flags  input  1  clears drop_cnt and timeout_flag.

Function
REQ-019 FSM states IDLE, LAUNCH, WAIT; reset state IDLE.
REQ-020 Strobe accepted only when state=IDLE and (out_valid=0 or out_ready=1); accepted strobe in cycle T captures operands and moves to LAUNCH at T+1.
REQ-021 fir_weight_adjust = sat16((mu * err_sample) >>> 15), full 32-bit signed product, arithmetic shift, truncation, clamp to [-32768, 32767].
REQ-022 fir_x_in, fir_a_in, fir_weight_adjust registered at acceptance and held stable until next acceptance.
REQ-023 LAUNCH: fir_go=1 for exactly that cycle; next state WAIT; wait counter cleared.
REQ-024 WAIT: fir_done=1 -> capture fir_out_sample into out_sample, out_valid=1 next cycle, state IDLE.
REQ-025 out_valid stays high, out_sample stable, until cycle with out_ready=1; then out_valid=0 unless a new result is captured same cycle.
REQ-026 Strobe not accepted (REQ-020) increments drop_cnt, saturating at 255; operands unchanged.
REQ-027 fir_done outside WAIT ignored; no output change.
REQ-028 mu_wr takes effect the cycle after assertion; mu_wr coincident with accepted strobe: old mu used for that sample.
REQ-029 clr_flags coincident with a drop: drop_cnt becomes 0 (clear wins).

Reset
REQ-030 rst asserted, at any state including mid-WAIT: state IDLE, fir_go=0, all fir_* operand outputs 0, out_sample=0, out_valid=0, busy=0, drop_cnt=0, timeout_flag=0, mu=MU_DEFAULT, wait counter 0.
REQ-031 fir_done arriving in first cycle after rst deassertion ignored (state IDLE).

Configuration
REQ-032 Macro ANC_FIR_SEQ_TIMEOUT_EN defined: WAIT counter increments each cycle; on reaching TIMEOUT_CYCLES without fir_done, state IDLE, timeout_flag=1 (sticky), no output produced.
REQ-033 Macro undefined: no counter, WAIT held indefinitely until fir_done, timeout_flag tied 0.

Verification
REQ-034 mu=16'sh4000, err=16'sh2000, x=16'sh1234, in_strobe at T -> fir_go at T+1 only, fir_weight_adjust=16'sh1000, fir_x_in=16'sh1234.
REQ-035 mu=16'sh8000, err=16'sh8000 -> fir_weight_adjust=16'sh7FFF (positive saturation).
REQ-036 fir_done with fir_out_sample=16'shABCD at T, out_ready=0 -> out_valid=1, out_sample=16'shABCD from T+1 held; out_ready=1 at T+5 -> out_valid=0 at T+6.
REQ-037 3 strobes during WAIT plus 300 strobes with out_valid stuck high -> drop_cnt=3 then saturates 255; clr_flags -> 0.
REQ-038 ANC_FIR_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=300, no fir_done -> timeout_flag=1, state IDLE, out_valid=0; next strobe accepted.
REQ-039 rst pulsed mid-WAIT then fir_done -> all outputs at reset values, out_valid stays 0.
